dlatch_stim_ctrl: RTL and testbench
===================================

Name: dlatch_stim_ctrl

Overview:
- Front-end stimulus stage that drives the En/D inputs of the NAND-built gated D latch from raw board inputs: a pushbutton (enable request) and a slide switch (data).
- Synchronizes and debounces both inputs, then issues one clean, fixed-width enable pulse per button press.
- Holds D stable from one cycle before the pulse until one cycle after it, so the latch sees setup and hold margin. Counts load events for the board LEDs.

Parameters:
- DEB_CYCLES, 50000, consecutive stable cycles required before a debounced output changes (1 ms at 50 MHz); must be >= 1.
- PULSE_CYCLES, 4, width of the en_out high window in clk cycles; must be >= 1.
- HOLDOFF_CYCLES, 16, lockout after each pulse during which new presses are ignored; 0 means no lockout.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- btn_raw, input, 1, asynchronous pushbutton, active-high, bouncy.
- sw_raw, input, 1, asynchronous slide switch, bouncy.
- en_out, output, 1, enable to latch En, registered.
- d_out, output, 1, data to latch D, registered.
- btn_clean, output, 1, debounced button level.
- busy, output, 1, high whenever the FSM is not in IDLE.
- load_count, output, 8, number of enable pulses issued; wraps 255 -> 0.

Behaviour:
- Reset: synchronous on the clk edge where rst_n = 0. Clears all flops to 0: synchronizers, debounce counters, clean levels, FSM = IDLE, en_out, d_out, btn_clean, busy, load_count. Reset mid-operation aborts immediately; en_out is 0 after that edge.
- Synchronizer: two flops per raw input. The first sample is visible in the second flop 2 cycles later.
- Debounce, per input:
  - The counter increments while the synchronized value differs from the clean value, and clears to 0 on any match.
  - When the counter reaches DEB_CYCLES, the clean value flips and the counter clears.
  - Result: clean rises DEB_CYCLES+2 cycles after a stable raw transition.
  - Counter width is clog2(DEB_CYCLES+1).
- Edge detect: press = btn_clean & ~btn_clean_d, where btn_clean_d is btn_clean delayed one cycle. Release edges generate nothing.
- FSM (Moore; outputs registered from next-state):
  - IDLE: en_out=0. On press, go to SETUP.
  - SETUP: 1 cycle. d_out <= sw_clean at entry. en_out=0.
  - PULSE: PULSE_CYCLES cycles. en_out=1. load_count increments once at entry.
  - HOLD: 1 cycle. en_out=0. d_out unchanged.
  - HOLDOFF: HOLDOFF_CYCLES cycles, skipped when 0. Then go to IDLE.
- Timing: if btn_clean rises in cycle N, then SETUP occupies cycle N+1 and en_out=1 for cycles N+2 .. N+1+PULSE_CYCLES.
- d_out holds its value from SETUP until the next SETUP. It never changes while en_out=1 or in HOLD.
- Press edges seen in any state other than IDLE are dropped, not queued.
- busy = (state != IDLE).
- load_count: 8-bit modulo arithmetic; increments only on PULSE entry.
- A btn press and sw change arriving in the same cycle: d_out takes whatever sw_clean is at SETUP entry.

Decomposition:
- Shared package dlatch_stim_pkg holds:
  - the state encoding: IDLE=0, SETUP=1, PULSE=2, HOLD=3, HOLDOFF=4, 3 bits;
  - default constants for DEB_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES;
  - the LOAD_CNT_W=8 constant.
- One sub-module, debounce_sync: 2-flop synchronizer plus counter debouncer, parameterized by DEB_CYCLES, clk/rst_n/in_raw/out_clean. Instantiated twice (button, switch).

Test Plan:
Bench parameters: DEB_CYCLES=4, PULSE_CYCLES=3, HOLDOFF_CYCLES=5.
1. Reset: rst_n=0 for 3 cycles with btn_raw=1, sw_raw=1 -> en_out, d_out, btn_clean, busy all 0 and load_count=0 throughout. No pulse within 6 cycles after release unless the debounce completes.
2. Clean press: sw_raw=1 held; btn_raw 0->1 held 30 cycles -> btn_clean rises 6 cycles after the first high sample. en_out high exactly 3 consecutive cycles starting 2 cycles later. d_out=1 from SETUP onward. busy high for 10 cycles. load_count=1.
3. Bounce: btn_raw toggles every 2 cycles for 12 cycles, then returns to 0 -> btn_clean stays 0, en_out never asserts, load_count=0.
4. Re-press in lockout: second clean press whose btn_clean rise lands during HOLDOFF -> no second pulse, load_count=1. A third press after busy falls -> pulse issued, load_count=2.
5. Data stability: sw_raw flips 1->0 such that sw_clean changes mid-PULSE -> d_out stays 1 through PULSE and HOLD. The next press loads d_out=0.
6. Reset mid-pulse plus wrap: rst_n=0 during the 2nd PULSE cycle -> en_out=0, busy=0, load_count=0 after that edge. Separately, 256 presses -> load_count returns to 0.

Source files
------------

// File: rtl/dlatch_stim_pkg.sv
// Shared definitions for the gated-D-latch stimulus controller: FSM encoding,
// default timing constants and a counter-width helper.
package dlatch_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int DEF_DEB_CYCLES     = 50000;
    localparam int DEF_PULSE_CYCLES   = 4;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int LOAD_CNT_W         = 8;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dlatch_stim_ctrl_debounce_sync.sv
// Two-flop synchronizer followed by a counting debouncer; the clean level only
// follows the synchronized input after it has disagreed for DEB_CYCLES+1 cycles.
module debounce_sync
    import dlatch_stim_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_raw,
    output logic out_clean
);

    localparam int              CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   DEB_MAX = CW'(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            out_clean <= 1'b0;
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
            // Any agreement restarts the count, so a bounce never accumulates.
            if (sync2 != out_clean) begin
                if (cnt == DEB_MAX) begin
                    out_clean <= sync2;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dlatch_stim_ctrl.sv
// Turns a bouncy pushbutton and slide switch into one clean En pulse per press,
// with D held stable from one cycle before the pulse to one cycle after it.
module dlatch_stim_ctrl
    import dlatch_stim_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_raw,
    input  logic                  sw_raw,
    output logic                  en_out,
    output logic                  d_out,
    output logic                  btn_clean,
    output logic                  busy,
    output logic [LOAD_CNT_W-1:0] load_count
);

    localparam int PH_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int PW     = cnt_width(PH_MAX);

    localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] HOLDOFF_LAST = PW'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

    logic    sw_clean;
    logic    btn_clean_d;
    logic    press;
    state_t  state;
    state_t  state_nx;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic    load_inc;
    logic    d_load;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_raw    (btn_raw),
        .out_clean (btn_clean)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_raw    (sw_raw),
        .out_clean (sw_clean)
    );

    assign press = btn_clean & ~btn_clean_d;

    // Presses outside IDLE fall through the case and are simply lost.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nx = ST_PULSE;
                phase_nx = '0;
            end
            ST_PULSE: begin
                if (phase == PULSE_LAST) begin
                    state_nx = ST_HOLD;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            ST_HOLD: begin
                phase_nx = '0;
                state_nx = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (phase == HOLDOFF_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                phase_nx = '0;
            end
        endcase
    end

    assign load_inc = (state_nx == ST_PULSE) && (state != ST_PULSE);
    assign d_load   = (state_nx == ST_SETUP) && (state != ST_SETUP);

    // Outputs are registered from the next state so they align with the state flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= '0;
            btn_clean_d <= 1'b0;
            en_out      <= 1'b0;
            d_out       <= 1'b0;
            busy        <= 1'b0;
            load_count  <= '0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            btn_clean_d <= btn_clean;
            en_out      <= (state_nx == ST_PULSE);
            busy        <= (state_nx != ST_IDLE);
            if (d_load) begin
                d_out <= sw_clean;
            end
            if (load_inc) begin
                load_count <= load_count + LOAD_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dlatch_stim_ctrl.sv
// Directed bench for dlatch_stim_ctrl with DEB_CYCLES=4, PULSE_CYCLES=3,
// HOLDOFF_CYCLES=5; cycle i below is the cycle following the i-th sampling edge.
module tb_dlatch_stim_ctrl;

    localparam int DEB     = 4;
    localparam int PULSE   = 3;
    localparam int HOLDOFF = 5;

    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic       sw_raw;
    logic       en_out;
    logic       d_out;
    logic       btn_clean;
    logic       busy;
    logic [7:0] load_count;

    int         errors;
    int         checks;
    logic [7:0] exp_loads;
    logic [0:0] exp_q[$];

    dlatch_stim_ctrl #(
        .DEB_CYCLES     (DEB),
        .PULSE_CYCLES   (PULSE),
        .HOLDOFF_CYCLES (HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .en_out     (en_out),
        .d_out      (d_out),
        .btn_clean  (btn_clean),
        .busy       (busy),
        .load_count (load_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // drivers: inputs change on the falling edge, outputs are read there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 20-cycle press: raw high for 8 samples, rise at cycle 6, pulse 8..10.
    task automatic do_press(input logic exp_d, input bit full_check);
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i < 8);
            tick();
            if (full_check) begin
                chk("press_en", en_out, (i >= 8 && i <= 10));
                chk("press_busy", busy, (i >= 7 && i <= 16));
                if (i >= 7) chk("press_d", d_out, exp_d);
            end
        end
        exp_loads = exp_loads + 8'd1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_loads = 8'd0;
        rst_n     = 1'b0;
        btn_raw   = 1'b1;
        sw_raw    = 1'b1;
        @(negedge clk);

        // 1. reset holds everything low even with raw inputs high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outs", {en_out, d_out, btn_clean, busy}, 4'b0000);
            chk("reset_load", load_count, 8'd0);
        end
        rst_n   = 1'b1;
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_reset_en", en_out, 1'b0);
            chk("post_reset_busy", busy, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick();

        // 2. clean press, switch high
        for (int i = 0; i < 20; i++) exp_q.push_back((i >= 8 && i <= 10) ? 1'b1 : 1'b0);
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("clean_en", en_out, exp_q.pop_front());
            chk("clean_btn", btn_clean, (i >= 6));
            chk("clean_busy", busy, (i >= 7 && i <= 16));
            if (i >= 7) chk("clean_d", d_out, 1'b1);
        end
        exp_loads = exp_loads + 8'd1;
        for (int i = 0; i < 10; i++) tick();
        chk("clean_load", load_count, exp_loads);
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("clean_release", btn_clean, 1'b0);

        // 3. bounce shorter than the debounce window
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i % 4) < 2);
            tick();
            chk("bounce_btn", btn_clean, 1'b0);
            chk("bounce_en", en_out, 1'b0);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bounce_en_tail", en_out, 1'b0);
        end
        chk("bounce_load", load_count, exp_loads);

        // 4. second rise lands in the last HOLDOFF cycle and is dropped
        for (int i = 0; i < 30; i++) begin
            btn_raw = (i < 5) || (i >= 10 && i < 20);
            tick();
            chk("lock_en", en_out, (i >= 8 && i <= 10));
            chk("lock_btn", btn_clean, (i >= 6 && i <= 10) || (i >= 16 && i <= 25));
            chk("lock_busy", busy, (i >= 7 && i <= 16));
        end
        exp_loads = exp_loads + 8'd1;
        chk("lock_load", load_count, exp_loads);
        do_press(1'b1, 1'b1);
        chk("third_load", load_count, exp_loads);

        // 5. switch changes mid-pulse; d_out must not follow until next SETUP
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i < 8);
            sw_raw  = (i < 3);
            tick();
            chk("stab_en", en_out, (i >= 8 && i <= 10));
            if (i >= 7) chk("stab_d", d_out, 1'b1);
        end
        exp_loads = exp_loads + 8'd1;
        do_press(1'b0, 1'b1);
        chk("stab_load", load_count, exp_loads);

        // 6. reset during the second pulse cycle, then wrap the load counter
        for (int i = 0; i < 11; i++) begin
            btn_raw = (i < 8);
            tick();
            if (i == 9) begin
                chk("midrst_en_before", en_out, 1'b1);
                rst_n = 1'b0;
            end
        end
        chk("midrst_en", en_out, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_load", load_count, 8'd0);
        rst_n     = 1'b1;
        btn_raw   = 1'b0;
        exp_loads = 8'd0;
        for (int i = 0; i < 12; i++) tick();
        for (int k = 0; k < 256; k++) begin
            do_press(1'b0, 1'b0);
            if (k == 254) chk("wrap_255", load_count, 8'd255);
        end
        chk("wrap_zero", load_count, 8'd0);
        chk("wrap_model", load_count, exp_loads);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
